// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master round-robin bus arbiter with a hold quota, a one-cycle
// turnaround between owners, and a combinational bus mux for the granted master.
module bus_arbiter #(
  parameter int SZ       = 8,
  parameter int WSZ      = 8,
  parameter int MAX_HOLD = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     req,
  output logic [1:0]     grant,
  output logic           owner,
  output logic           preempt,
  input  logic [SZ-1:0]  m0_addr,
  input  logic [SZ-1:0]  m1_addr,
  input  logic [WSZ-1:0] m0_wdata,
  input  logic [WSZ-1:0] m1_wdata,
  input  logic           m0_w_notr,
  input  logic           m1_w_notr,
  output logic [SZ-1:0]  bus_addr,
  output logic [WSZ-1:0] bus_wdata,
  output logic           bus_w_notr
);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] LIM = HW'(MAX_HOLD - 1);
  localparam logic [HW-1:0] TOP = HW'(MAX_HOLD);
  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, TURN} state_t;
  state_t state, next;
  logic [HW-1:0] hold_cnt;
  logic last_owner, preempt_d, cur, granted, enter;
  assign granted = state == GRANT0 || state == GRANT1;
  assign cur     = state == GRANT1;
  assign enter   = !granted && (next == GRANT0 || next == GRANT1);
  // Release wins over quota; >= keeps the quota live once the count has saturated.
  always_comb begin
    next      = state;
    preempt_d = 1'b0;
    if (!granted)
      next = req == 2'b00 ? IDLE :
             req == 2'b11 ? (last_owner ? GRANT0 : GRANT1) :
             req[1] ? GRANT1 : GRANT0;
    else if (!req[cur])
      next = TURN;
    else if (req[!cur] && hold_cnt >= LIM) begin
      next      = TURN;
      preempt_d = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      preempt    <= 1'b0;
      hold_cnt   <= '0;
      last_owner <= 1'b0;
    end else begin
      state   <= next;
      preempt <= preempt_d;
      if (enter) begin
        hold_cnt   <= '0;
        last_owner <= next == GRANT1;
      end else if (granted)
        hold_cnt <= hold_cnt == TOP ? hold_cnt : hold_cnt + HW'(1);
    end
  end
  assign owner      = last_owner;
  assign grant      = {state == GRANT1, state == GRANT0};
  assign bus_addr   = grant[0] ? m0_addr   : grant[1] ? m1_addr   : '0;
  assign bus_wdata  = grant[0] ? m0_wdata  : grant[1] ? m1_wdata  : '0;
  assign bus_w_notr = grant[0] ? m0_w_notr : grant[1] ? m1_w_notr : 1'b0;
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter SZ, default 8, address bus width.
REQ-002 SHALL have parameter WSZ, default 8, data bus width.
REQ-003 SHALL have parameter MAX_HOLD, default 8, max consecutive owned cycles while the other master waits; legal range >= 1.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req  input  2  bus request; bit0 = cpu (m0), bit1 = dma (m1).
REQ-007 SHALL have port grant  output  2  registered one-hot grant, or 0.
REQ-008 SHALL have port owner  output  1  index of the last granted master; holds its value while no grant is active.
REQ-009 SHALL have port preempt  output  1  one-cycle pulse when a grant is revoked by quota.
REQ-010 SHALL have ports m0_addr/m1_addr  input  SZ, m0_wdata/m1_wdata  input  WSZ, m0_w_notr/m1_w_notr  input  1  per-master bus drive.
REQ-011 SHALL have port bus_addr  output  SZ  muxed shared address.
REQ-012 SHALL have port bus_wdata  output  WSZ  muxed write data.
REQ-013 SHALL have port bus_w_notr  output  1  muxed write strobe; 1 = write.

Function
REQ-014 SHALL implement states IDLE, GRANT0, GRANT1, TURN.
REQ-015 IDLE/TURN, one req bit high -> GRANTx for that master at the sampling edge; grant visible after that edge, so latency is 1 edge.
REQ-016 IDLE/TURN, both req high -> grant the master != last_owner (round-robin); last_owner resets to 0, so the first contention goes to m1.
REQ-017 IDLE/TURN, req = 0 -> IDLE.
REQ-018 GRANTx, req[x] sampled low -> TURN; grant = 0 from that edge.
REQ-019 TURN SHALL last exactly one cycle with grant = 0 (bus turnaround), even if the same master re-requests.
REQ-020 On entry to GRANTx, hold_cnt SHALL clear to 0. Each cycle in GRANTx it increments, saturating at MAX_HOLD. Width is $clog2(MAX_HOLD+1).
REQ-021 GRANTx with req[x] high, req[other] high and hold_cnt == MAX_HOLD-1 -> TURN with preempt = 1 for one cycle; the revoked master's req may stay high.
REQ-022 If the other master is not requesting, quota SHALL NOT revoke; ownership is unbounded.
REQ-023 Release and quota expiry on the same edge SHALL count as a release; preempt stays 0.
REQ-024 last_owner and owner SHALL update at every entry to GRANTx.
REQ-025 bus_addr, bus_wdata and bus_w_notr SHALL combinationally select the granted master's inputs while grant != 0, and be 0 otherwise.
REQ-026 grant SHALL never have both bits set; bus_w_notr SHALL be 0 in IDLE and TURN.

Reset
REQ-027 rst low SHALL immediately force state=IDLE, grant=0, owner=0, preempt=0, hold_cnt=0, last_owner=0 and bus outputs=0, including mid-grant.
REQ-028 First grant after rst rises SHALL follow REQ-015/016 with no extra delay.

Verification (SZ=8, WSZ=8, MAX_HOLD=4)
REQ-029 req=01 from IDLE at edge 1 -> grant=01 after edge 1. m0_addr=5, m0_wdata=3, m0_w_notr=1 -> bus_addr=5, bus_wdata=3, bus_w_notr=1.
REQ-030 req=11 from reset -> grant=10 (dma). Hold req=11 -> grant=10 for exactly 4 cycles, then preempt=1 and grant=00 for 1 cycle, then grant=01.
REQ-031 req=10 held 20 cycles with req[0]=0 -> grant=10 throughout, preempt never asserted.
REQ-032 m1 owns, req drops to 00 -> grant=00 next edge. req=10 reasserted immediately -> one TURN cycle, then grant=10. owner=1 throughout.
REQ-033 rst pulsed low mid-GRANT1 with m1_w_notr=1 -> grant=00, bus_w_notr=0, bus_addr=0 without waiting for clk. After release with req=11 -> grant=10.
REQ-034 m0 owns with req=11 and hold_cnt=3 while req[0] drops on the same edge -> TURN, preempt=0, then grant=10.
